// File: rtl/svm_dot_accum.sv
// Streaming multiply-accumulate: one signed dot product per support vector,
// with partial-vector flush on stop and a sticky overrun flag.
module svm_dot_accum #(
  parameter int Features  = 4,
  parameter int Vectors   = 8,
  parameter int DataWidth = 16,
  parameter int AccWidth  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_start,
  input  logic                 in_valid,
  input  logic                 in_stop,
  input  logic [DataWidth-1:0] sv_data,
  input  logic [DataWidth-1:0] x_data,
  output logic                 out_valid,
  output logic [31:0]          out_vector,
  output logic [AccWidth-1:0]  out_dot,
  output logic                 out_partial,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int FW = (Features > 1) ? $clog2(Features) : 1;
  localparam logic [FW-1:0] FeatLast = FW'(Features - 1);
  localparam int PW = 2 * DataWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [FW-1:0]       feat_cnt;
  logic [31:0]         vec_cnt;
  logic [AccWidth-1:0] acc;

  logic signed [PW-1:0] prod;
  logic [AccWidth-1:0]  sum;
  logic                 beat;
  logic                 vec_done;
  logic                 vec_full;
  logic [FW-1:0]        feat_after;
  logic [AccWidth-1:0]  acc_after;

  // Accumulator and counter values after this cycle's beat; the stop flush
  // looks at these so a completing beat plus stop yields a single result.
  always_comb begin
    prod       = $signed(sv_data) * $signed(x_data);
    sum        = acc + {{(AccWidth-PW){prod[PW-1]}}, prod};
    vec_full   = (vec_cnt == 32'(Vectors));
    beat       = (state == ACCUM) && in_valid && !in_start && !vec_full;
    vec_done   = beat && (feat_cnt == FeatLast);
    feat_after = feat_cnt;
    acc_after  = acc;
    if (vec_done) begin
      feat_after = '0;
      acc_after  = '0;
    end else if (beat) begin
      feat_after = feat_cnt + 1'b1;
      acc_after  = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      feat_cnt    <= '0;
      vec_cnt     <= '0;
      acc         <= '0;
      out_valid   <= 1'b0;
      out_vector  <= '0;
      out_dot     <= '0;
      out_partial <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_start) begin
        state    <= ACCUM;
        feat_cnt <= '0;
        vec_cnt  <= '0;
        acc      <= '0;
        overrun  <= 1'b0;
      end else if (state == ACCUM) begin
        feat_cnt <= feat_after;
        acc      <= acc_after;
        if (in_valid && vec_full)
          overrun <= 1'b1;
        if (vec_done) begin
          out_dot     <= sum;
          out_vector  <= vec_cnt;
          out_partial <= 1'b0;
          out_valid   <= 1'b1;
          vec_cnt     <= vec_cnt + 32'd1;
        end
        if (in_stop) begin
          state      <= DONE;
          frame_done <= 1'b1;
          if (feat_after != '0) begin
            out_dot     <= acc_after;
            out_vector  <= vec_cnt;
            out_partial <= 1'b1;
            out_valid   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_svm_dot_accum.sv
// Directed-vector bench for svm_dot_accum: two instances (Vectors=2 and
// Vectors=1) share stimulus; expected values are hand-computed constants.
module tb_svm_dot_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start, in_valid, in_stop;
  logic [15:0] sv_data, x_data;

  logic        out_valid,   out_valid1;
  logic [31:0] out_vector,  out_vector1;
  logic [47:0] out_dot,     out_dot1;
  logic        out_partial, out_partial1;
  logic        frame_done,  frame_done1;
  logic        overrun,     overrun1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  svm_dot_accum #(.Features(4), .Vectors(2), .DataWidth(16), .AccWidth(48)) u_dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid), .in_stop(in_stop),
    .sv_data(sv_data), .x_data(x_data), .out_valid(out_valid), .out_vector(out_vector),
    .out_dot(out_dot), .out_partial(out_partial), .frame_done(frame_done), .overrun(overrun)
  );

  svm_dot_accum #(.Features(4), .Vectors(1), .DataWidth(16), .AccWidth(48)) u_dut1 (
    .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid), .in_stop(in_stop),
    .sv_data(sv_data), .x_data(x_data), .out_valid(out_valid1), .out_vector(out_vector1),
    .out_dot(out_dot1), .out_partial(out_partial1), .frame_done(frame_done1), .overrun(overrun1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [63:0] d48(input longint v);
    logic [47:0] t;
    t = v[47:0];
    return {16'd0, t};
  endfunction

  // One clock: drive inputs, let the edge sample them, settle, then release pulses.
  task automatic drive(input logic st, input logic v, input logic sp,
                       input logic [15:0] sv, input logic [15:0] x);
    in_start = st;
    in_valid = v;
    in_stop  = sp;
    sv_data  = sv;
    x_data   = x;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_valid = 1'b0;
    in_stop  = 1'b0;
  endtask

  task automatic beat(input logic [15:0] sv, input logic [15:0] x);
    drive(1'b0, 1'b1, 1'b0, sv, x);
  endtask

  initial begin
    rst = 1'b1;
    in_start = 1'b0; in_valid = 1'b0; in_stop = 1'b0;
    sv_data = '0; x_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   {63'd0, out_valid},   64'd0);
    check("rst_vector",  {32'd0, out_vector},  64'd0);
    check("rst_dot",     {16'd0, out_dot},     64'd0);
    check("rst_partial", {63'd0, out_partial}, 64'd0);
    check("rst_done",    {63'd0, frame_done},  64'd0);
    check("rst_overrun", {63'd0, overrun},     64'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Full frame: 2*(1+2+3+4)=20, then -20
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    beat(16'd1, 16'd2);
    beat(16'd2, 16'd2);
    beat(16'd3, 16'd2);
    check("full_no_early_valid", {63'd0, out_valid}, 64'd0);
    beat(16'd4, 16'd2);
    check("full_v0_valid",   {63'd0, out_valid},   64'd1);
    check("full_v0_vector",  {32'd0, out_vector},  64'd0);
    check("full_v0_dot",     {16'd0, out_dot},     d48(20));
    check("full_v0_partial", {63'd0, out_partial}, 64'd0);
    beat(-16'sd1, 16'd2);
    check("full_valid_pulse", {63'd0, out_valid}, 64'd0);
    check("full_dot_hold",    {16'd0, out_dot},   d48(20));
    beat(-16'sd2, 16'd2);
    beat(-16'sd3, 16'd2);
    beat(-16'sd4, 16'd2);
    check("full_v1_valid",  {63'd0, out_valid},  64'd1);
    check("full_v1_vector", {32'd0, out_vector}, 64'd1);
    check("full_v1_dot",    {16'd0, out_dot},    d48(-20));
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check("full_done",       {63'd0, frame_done}, 64'd1);
    check("full_stop_noout", {63'd0, out_valid},  64'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("full_done_pulse", {63'd0, frame_done}, 64'd0);

    // Partial flush: 5*3+7*3 = 36
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    beat(16'd5, 16'd3);
    beat(16'd7, 16'd3);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check("part_valid",   {63'd0, out_valid},   64'd1);
    check("part_dot",     {16'd0, out_dot},     d48(36));
    check("part_vector",  {32'd0, out_vector},  64'd0);
    check("part_partial", {63'd0, out_partial}, 64'd1);
    check("part_done",    {63'd0, frame_done},  64'd1);

    // Coincident completing beat and stop: 1+2+3+4 = 10
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    beat(16'd1, 16'd1);
    beat(16'd2, 16'd1);
    beat(16'd3, 16'd1);
    drive(1'b0, 1'b1, 1'b1, 16'd4, 16'd1);
    check("coin_valid",   {63'd0, out_valid},   64'd1);
    check("coin_dot",     {16'd0, out_dot},     d48(10));
    check("coin_partial", {63'd0, out_partial}, 64'd0);
    check("coin_done",    {63'd0, frame_done},  64'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("coin_single", {63'd0, out_valid}, 64'd0);

    // Overrun on the Vectors=1 instance
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    check("ovr_v0_valid", {63'd0, out_valid1}, 64'd1);
    check("ovr_v0_dot",   {16'd0, out_dot1},   d48(4));
    check("ovr_clear_before", {63'd0, overrun1}, 64'd0);
    beat(16'd9, 16'd9);
    check("ovr_set",      {63'd0, overrun1},   64'd1);
    check("ovr_no_out5",  {63'd0, out_valid1}, 64'd0);
    beat(16'd9, 16'd9);
    check("ovr_no_out6",  {63'd0, out_valid1}, 64'd0);
    check("ovr_sticky",   {63'd0, overrun1},   64'd1);
    check("ovr_dot_hold", {16'd0, out_dot1},   d48(4));
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    check("ovr_cleared",  {63'd0, overrun1},   64'd0);

    // Sign extremes: 4 * (-32768)^2 = 2^32
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) beat(16'h8000, 16'h8000);
    check("ext_valid", {63'd0, out_valid}, 64'd1);
    check("ext_dot",   {16'd0, out_dot},   64'd4294967296);
    beat(16'd50, 16'd50);
    beat(16'd50, 16'd50);
    // Restart with a beat in the start cycle: that beat must be ignored
    drive(1'b1, 1'b1, 1'b0, 16'd100, 16'd1);
    check("rs_no_out", {63'd0, out_valid}, 64'd0);
    repeat (4) beat(16'd1, 16'd1);
    check("rs_valid",  {63'd0, out_valid},  64'd1);
    check("rs_vector", {32'd0, out_vector}, 64'd0);
    check("rs_dot",    {16'd0, out_dot},    d48(4));

    // Reset mid-frame
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    beat(16'd3, 16'd3);
    beat(16'd3, 16'd3);
    beat(16'd3, 16'd3);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'd3, 16'd3);
    rst = 1'b0;
    check("mrst_valid",  {63'd0, out_valid},  64'd0);
    check("mrst_dot",    {16'd0, out_dot},    64'd0);
    check("mrst_vector", {32'd0, out_vector}, 64'd0);
    check("mrst_done",   {63'd0, frame_done}, 64'd0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check("mrst_idle_stop", {63'd0, frame_done}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) beat(16'd2, 16'd3);
    check("post_valid",  {63'd0, out_valid},  64'd1);
    check("post_vector", {32'd0, out_vector}, 64'd0);
    check("post_dot",    {16'd0, out_dot},    d48(24));
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check("post_done",   {63'd0, frame_done}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
